// File: rtl/l_scan_pkg.sv
// l_scan_pkg: state encoding and column codes shared by the L-scan scheduler.
package l_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RESTART,
        PRIME,
        STREAM,
        SAMPLE,
        ABORT
    } lscan_state_t;

    localparam logic [2:0] COL_BLANK = 3'b000;
    localparam logic [2:0] COL_BAR   = 3'b111;
    localparam logic [2:0] COL_FOOT  = 3'b001;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after rr_ptr.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int GW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   rr_ptr,
    output logic [NREQ-1:0] grant_oh,
    output logic [GW-1:0]   grant_idx
);
    logic found;
    int   idx;

    // NOTE: every combinationally driven signal gets a default first; otherwise
    // paths that skip an assignment would infer a latch.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                found         = 1'b1;
                grant_oh[idx] = 1'b1;
                grant_idx     = GW'(idx);
            end
        end
    end

endmodule

// File: rtl/l_scan_sched.sv
// l_scan_sched: shares one L-recognizer among NREQ column streams, round-robin per token.
// Define L_SCAN_STATS_EN to add saturating hit_count / err_count outputs.
module l_scan_sched
    import l_scan_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int MAXCOLS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [3*NREQ-1:0] col_data,
    input  logic [NREQ-1:0]   col_valid,
    input  logic [NREQ-1:0]   col_last,
    output logic [NREQ-1:0]   col_ready,
    output logic [2:0]        rd_bits,
    output logic              rd_restart,
    input  logic              rd_L,
    output logic [NREQ-1:0]   done,
    output logic              hit,
    output logic              err
`ifdef L_SCAN_STATS_EN
    ,
    output logic [7:0]        hit_count,
    output logic [7:0]        err_count
`endif
);
    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(MAXCOLS) + 1;

    lscan_state_t    state, state_nx;
    logic [GW-1:0]   gnt, rr_ptr, grant_idx;
    logic [NREQ-1:0] grant_oh;
    logic [CW-1:0]   colcnt;
    logic            gnt_valid, gnt_last;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req      (req),
        .rr_ptr   (rr_ptr),
        .grant_oh (grant_oh),
        .grant_idx(grant_idx)
    );

    assign gnt_valid = col_valid[gnt];
    assign gnt_last  = col_last[gnt];

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|grant_oh) state_nx = RESTART;
            RESTART: state_nx = PRIME;
            PRIME:   state_nx = STREAM;
            // The recognizer has no enable, so any bubble ruins the scan.
            STREAM: begin
                if (!gnt_valid)                       state_nx = ABORT;
                else if (gnt_last)                    state_nx = SAMPLE;
                else if (colcnt == CW'(MAXCOLS - 1))  state_nx = ABORT;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        col_ready  = '0;
        done       = '0;
        rd_bits    = COL_BLANK;
        rd_restart = 1'b0;
        hit        = 1'b0;
        err        = 1'b0;
        case (state)
            RESTART: rd_restart = 1'b1;
            STREAM: begin
                col_ready[gnt] = 1'b1;
                if (gnt_valid) rd_bits = col_data[3*int'(gnt) +: 3];
            end
            SAMPLE: begin
                done[gnt] = 1'b1;
                hit       = rd_L;
            end
            ABORT: begin
                done[gnt] = 1'b1;
                err       = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            gnt    <= '0;
            rr_ptr <= '0;
            colcnt <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE:   if (|grant_oh) gnt <= grant_idx;
                PRIME:  colcnt <= '0;
                STREAM: if (gnt_valid) colcnt <= colcnt + 1'b1;
                SAMPLE, ABORT: rr_ptr <= (int'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef L_SCAN_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count <= '0;
            err_count <= '0;
        end else begin
            if (state == SAMPLE && rd_L && hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
            if (state == ABORT && err_count != 8'hFF)          err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_l_scan_sched.sv
// tb_l_scan_sched: randomized and directed tokens checked against a token-level model
// (round-robin service order, L-pattern hit, abort rules, latency).
`timescale 1ns/1ps
module tb_l_scan_sched;
    import l_scan_pkg::*;

    localparam int NREQ    = 4;
    localparam int MAXCOLS = 16;
    localparam int MAXTOK  = 20;

    logic              clk       = 1'b0;
    logic              reset     = 1'b0;
    logic [NREQ-1:0]   req       = '0;
    logic [3*NREQ-1:0] col_data  = '0;
    logic [NREQ-1:0]   col_valid = '0;
    logic [NREQ-1:0]   col_last  = '0;
    logic [NREQ-1:0]   col_ready, done;
    logic [2:0]        rd_bits;
    logic              rd_restart;
    logic              rd_L      = 1'b0;
    logic              hit, err;

    always #5 clk = ~clk;

    l_scan_sched #(.NREQ(NREQ), .MAXCOLS(MAXCOLS)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .col_data  (col_data),
        .col_valid (col_valid),
        .col_last  (col_last),
        .col_ready (col_ready),
        .rd_bits   (rd_bits),
        .rd_restart(rd_restart),
        .rd_L      (rd_L),
        .done      (done),
        .hit       (hit),
        .err       (err)
    );

    // L shape since restart: blank, one or more bars, one or more feet, blank.
    function automatic bit l_match(input logic [2:0] q[$]);
        int i;
        int n;
        n = q.size();
        if (n < 4 || q[0] != COL_BLANK || q[1] != COL_BAR) return 1'b0;
        i = 1;
        while (i < n && q[i] == COL_BAR) i++;
        if (i >= n || q[i] != COL_FOOT) return 1'b0;
        while (i < n && q[i] == COL_FOOT) i++;
        return (i == n - 1) && (q[i] == COL_BLANK);
    endfunction

    // Behavioural recognizer: registered L over the column history since restart.
    logic [2:0] rq[$];
    always @(posedge clk) begin
        if (rd_restart) rq.delete();
        else            rq.push_back(rd_bits);
        rd_L <= l_match(rq);
    end

    logic [2:0]      tcol [NREQ][MAXTOK];
    int              tlen [NREQ];
    int              tpos [NREQ];
    int              tbub [NREQ];
    bit              tlast[NREQ];
    bit              active[NREQ];
    bit              exp_hit[NREQ];
    bit              exp_err[NREQ];
    int              exp_acc[NREQ];
    logic [NREQ-1:0] pending, acc_mask, prev_ready;
    int              ptr, exp_next, cyc, t_ready, t_raise, reraise_left;
    bit              chk_raise_lat;
    logic            rs_d1, rs_d2;
    logic [2:0]      bits_d1;
    int              n_tests, n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] p, input int from);
        for (int k = 0; k < NREQ; k++)
            if (p[(from + k) % NREQ]) return (from + k) % NREQ;
        return -1;
    endfunction

    task automatic load_cols(input int r, input logic [2:0] q[$], input int bub, input bit last);
        logic [2:0] hq[$];
        tlen[r]   = q.size();
        tpos[r]   = 0;
        tbub[r]   = bub;
        tlast[r]  = last;
        active[r] = 1'b1;
        foreach (q[k]) tcol[r][k] = q[k];
        if (bub >= 0) begin
            exp_err[r] = 1'b1; exp_hit[r] = 1'b0; exp_acc[r] = bub;
        end else if (!last) begin
            exp_err[r] = 1'b1; exp_hit[r] = 1'b0; exp_acc[r] = MAXCOLS;
        end else begin
            hq = q;
            hq.push_front(COL_BLANK);
            exp_err[r] = 1'b0; exp_hit[r] = l_match(hq); exp_acc[r] = q.size();
        end
    endtask

    task automatic load_token(input int r, input int kind);
        logic [2:0] q[$];
        int bub;
        bit last;
        bub  = -1;
        last = 1'b1;
        case (kind)
            0, 1: begin
                repeat ($urandom_range(1, 3)) q.push_back(COL_BAR);
                repeat ($urandom_range(1, 3)) q.push_back(COL_FOOT);
                q.push_back(COL_BLANK);
                if (kind == 1) q[$urandom_range(0, q.size() - 1)] = 3'($urandom);
            end
            2: repeat ($urandom_range(1, 8)) q.push_back(3'($urandom));
            3: begin
                repeat ($urandom_range(2, 6)) q.push_back(3'($urandom));
                bub = $urandom_range(0, q.size() - 1);
            end
            4: begin
                repeat (MAXCOLS) q.push_back(3'($urandom));
                last = 1'b0;
            end
            default: begin
                repeat (7) q.push_back(COL_BAR);
                repeat (8) q.push_back(COL_FOOT);
                q.push_back(COL_BLANK);
            end
        endcase
        load_cols(r, q, bub, last);
    endtask

    task automatic raise_mask(input logic [NREQ-1:0] m);
        req      = req | m;
        pending  = pending | m;
        exp_next = pick(pending, ptr);
    endtask

    task automatic drive();
        bit have;
        for (int i = 0; i < NREQ; i++) begin
            if (active[i]) begin
                have             = tpos[i] < tlen[i];
                col_valid[i]     = have && (tpos[i] != tbub[i]);
                col_data[3*i +: 3] = have ? tcol[i][tpos[i]] : 3'($urandom);
                col_last[i]      = have && tlast[i] && (tpos[i] == tlen[i] - 1);
            end else begin
                col_valid[i]     = 1'($urandom);
                col_data[3*i +: 3] = 3'($urandom);
                col_last[i]      = 1'($urandom);
            end
        end
    endtask

    task automatic sample();
        int gi;
        acc_mask = col_ready & col_valid;
        gi       = exp_next;
        if (col_ready != '0 && prev_ready == '0) begin
            t_ready = cyc;
            check("grant", 32'(col_ready), gi >= 0 ? 32'(1) << gi : 32'd0);
            check("prime_seq", {rs_d2, rs_d1, bits_d1}, 32'b10000);
        end
        if (col_ready != '0 && gi >= 0 && !col_valid[gi])
            check("bubble_bits", rd_bits, COL_BLANK);
        if (done != '0) begin
            check("done", 32'(done), gi >= 0 ? 32'(1) << gi : 32'd0);
            if (gi >= 0) begin
                check("hit", hit, exp_hit[gi]);
                check("err", err, exp_err[gi]);
                check("latency", cyc - t_ready, exp_acc[gi] + int'(tbub[gi] >= 0));
                if (chk_raise_lat) begin
                    check("req_to_done", cyc - t_raise, 6);
                    chk_raise_lat = 1'b0;
                end
                req[gi]     = 1'b0;
                pending[gi] = 1'b0;
                active[gi]  = 1'b0;
                ptr         = (gi + 1) % NREQ;
                // A requester re-raising right away must wait behind the others.
                if (reraise_left > 0 && $urandom_range(0, 1) == 1) begin
                    reraise_left--;
                    load_token(gi, $urandom_range(0, 5));
                    req[gi]     = 1'b1;
                    pending[gi] = 1'b1;
                end
                exp_next = pick(pending, ptr);
            end
        end
        rs_d2      = rs_d1;
        rs_d1      = rd_restart;
        bits_d1    = rd_bits;
        prev_ready = col_ready;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        for (int i = 0; i < NREQ; i++) if (acc_mask[i]) tpos[i]++;
        #1;
        drive();
        @(negedge clk);
        sample();
    endtask

    task automatic run_idle(input int budget);
        int n;
        n = 0;
        while (pending != '0 && n < budget) begin
            step();
            n++;
        end
        check("timeout", 32'(pending), 32'd0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ready"}, 32'(col_ready), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_hit"}, hit, 1'b0);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_restart"}, rd_restart, 1'b0);
        check({tag, "_bits"}, rd_bits, COL_BLANK);
    endtask

    task automatic model_reset();
        req        = '0;
        pending    = '0;
        acc_mask   = '0;
        prev_ready = '0;
        ptr        = 0;
        exp_next   = -1;
        for (int i = 0; i < NREQ; i++) active[i] = 1'b0;
    endtask

    logic [2:0] dq[$];
    int         n;

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; t_ready = 0; t_raise = 0;
        reraise_left = 0; chk_raise_lat = 1'b0;
        rs_d1 = 1'b0; rs_d2 = 1'b0; bits_d1 = '0;
        for (int i = 0; i < NREQ; i++) begin
            tlen[i] = 0; tpos[i] = 0; tbub[i] = -1; tlast[i] = 1'b0;
        end
        model_reset();

        repeat (3) @(negedge clk);
        check_quiet("rst");
        reset = 1'b1;
        step();
        check_quiet("idle");

        // Requester 0: bar, foot, blank -> hit, done in the 6th cycle after req rises.
        dq.delete(); dq.push_back(COL_BAR); dq.push_back(COL_FOOT); dq.push_back(COL_BLANK);
        load_cols(0, dq, -1, 1'b1);
        t_raise = cyc; chk_raise_lat = 1'b1;
        raise_mask(4'b0001);
        run_idle(200);

        // Requester 1 alone moves the pointer to 2.
        load_token(1, 2);
        raise_mask(4'b0010);
        run_idle(200);

        // Requesters 1 and 3 together with pointer at 2: 3 first, then 1.
        load_token(1, 0);
        load_token(3, 2);
        raise_mask(4'b1010);
        run_idle(200);

        // Requester 2: bar, 011, blank -> miss.
        dq.delete(); dq.push_back(COL_BAR); dq.push_back(3'b011); dq.push_back(COL_BLANK);
        load_cols(2, dq, -1, 1'b1);
        raise_mask(4'b0100);
        run_idle(200);

        // Requester 3 drops valid after one column.
        dq.delete(); dq.push_back(COL_BAR); dq.push_back(COL_BAR); dq.push_back(COL_BLANK);
        load_cols(3, dq, 1, 1'b1);
        raise_mask(4'b1000);
        run_idle(200);

        // Requester 0 overruns MAXCOLS, then 0 and 1 compete: 1 goes first.
        load_token(0, 4);
        raise_mask(4'b0001);
        run_idle(200);
        load_token(0, 0);
        load_token(1, 5);
        raise_mask(4'b0011);
        run_idle(200);

        // Reset in the middle of a stream, then a fresh token.
        dq.delete();
        repeat (8) dq.push_back(COL_BAR);
        load_cols(1, dq, -1, 1'b1);
        raise_mask(4'b0010);
        n = 0;
        while (col_ready == '0 && n < 20) begin
            step();
            n++;
        end
        check("stream_reached", 32'(col_ready), 32'b0010);
        step();
        step();
        #2 reset = 1'b0;
        #1;
        check_quiet("midrst");
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        step();
        dq.delete(); dq.push_back(COL_BAR); dq.push_back(COL_BAR);
        dq.push_back(COL_FOOT); dq.push_back(COL_BLANK);
        load_cols(2, dq, -1, 1'b1);
        raise_mask(4'b0100);
        run_idle(200);

        // Random rounds with random requester sets and occasional re-requests.
        for (int r = 0; r < 60; r++) begin
            logic [NREQ-1:0] m;
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) if (m[i]) load_token(i, $urandom_range(0, 5));
            reraise_left = $urandom_range(0, 2);
            raise_mask(m);
            run_idle(800);
            repeat ($urandom_range(0, 2)) step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
